// File: rtl/stopwatch.sv
// Six-digit BCD stopwatch (MM:SS.hh) with a 100 Hz prescaler and level-sensitive run enable.
// Optional build macro STOPWATCH_SATURATE_EN: hold at 59:59.99 instead of wrapping to 00:00.00.
module stopwatch #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        toggle,
   output logic [23:0] disp_time
);

   localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [23:0]   r_time;

   logic          w_tick;
   logic          w_at_max;
   logic [5:0]    w_c;
   logic [23:0]   w_next;

   // Next value of one digit when a carry arrives: roll to 0 past its limit.
   function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
      bcd_inc = (d >= lim) ? 4'd0 : d + 4'd1;
   endfunction

   assign w_tick   = toggle && (r_presc == PMAX);
   assign w_at_max = (r_time == 24'h595999);

   // Carry ripples from hundredths ones up to minute tens.
   always_comb begin
      w_c    = 6'b000001;
      w_next = r_time;
      w_c[1] = w_c[0] && (r_time[3:0]   >= 4'd9);
      w_c[2] = w_c[1] && (r_time[7:4]   >= 4'd9);
      w_c[3] = w_c[2] && (r_time[11:8]  >= 4'd9);
      w_c[4] = w_c[3] && (r_time[15:12] >= 4'd5);
      w_c[5] = w_c[4] && (r_time[19:16] >= 4'd9);
      w_next[3:0]   = bcd_inc(r_time[3:0],   4'd9);
      w_next[7:4]   = w_c[1] ? bcd_inc(r_time[7:4],   4'd9) : r_time[7:4];
      w_next[11:8]  = w_c[2] ? bcd_inc(r_time[11:8],  4'd9) : r_time[11:8];
      w_next[15:12] = w_c[3] ? bcd_inc(r_time[15:12], 4'd5) : r_time[15:12];
      w_next[19:16] = w_c[4] ? bcd_inc(r_time[19:16], 4'd9) : r_time[19:16];
      w_next[23:20] = w_c[5] ? bcd_inc(r_time[23:20], 4'd5) : r_time[23:20];
   end

   // Paused state keeps the partial prescaler count so a resume finishes the same hundredth.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_time  <= 24'h000000;
      end else if (toggle) begin
         if (w_tick) begin
            r_presc <= '0;
`ifdef STOPWATCH_SATURATE_EN
            if (!w_at_max) r_time <= w_next;
`else
            r_time <= w_at_max ? 24'h000000 : w_next;
`endif
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   assign disp_time = r_time;

endmodule

// File: tb/tb_stopwatch.sv
// Scoreboard bench for stopwatch at TICK_DIV=4: stimulus queues timed expectations, a monitor checks them.
module tb_stopwatch;

   localparam int TICK_DIV = 4;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        toggle = 1'b0;
   logic [23:0] disp_time;

   stopwatch #(.TICK_DIV(TICK_DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .toggle    (toggle),
      .disp_time (disp_time)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [23:0] val;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc_cnt  = 0;
   bit          mon_on   = 1'b0;
   logic [23:0] preload_v = 24'h000000;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic expect_at(input int n, input logic [23:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc_cnt + n;
      e.val  = v;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit digits_ok(input logic [23:0] d);
      return (d[23:20] <= 4'd5) && (d[19:16] <= 4'd9) && (d[15:12] <= 4'd5) &&
             (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
   endfunction

   // Monitor: per-cycle digit range check plus scoreboard pops at their due cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            n_checks++;
            if (!digits_ok(disp_time)) begin
               n_fail++;
               $display("FAIL digit_range cyc=%0d: got %h, required all digits in range", cyc_cnt, disp_time);
            end
         end
         while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            e = q.pop_front();
            n_checks++;
            if (e.cyc != cyc_cnt) begin
               n_fail++;
               $display("FAIL %s: check missed (due cyc %0d, now %0d), required %h", e.name, e.cyc, cyc_cnt, e.val);
            end else if (disp_time !== e.val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d: got %h, required %h", e.name, cyc_cnt, disp_time, e.val);
            end
         end
      end
   end

   initial begin
      reset  = 1'b1;
      toggle = 1'b0;
      run(3);
      mon_on = 1'b1;

      // Count from reset: first tick after TICK_DIV edges, then one every TICK_DIV.
      reset  = 1'b0;
      toggle = 1'b1;
      expect_at(1,  24'h000000, "reset_state");
      expect_at(3,  24'h000000, "before_first_tick");
      expect_at(4,  24'h000001, "first_tick");
      expect_at(44, 24'h000011, "eleven");
      run(44);
      expect_at(352, 24'h000099, "hund_99");
      expect_at(356, 24'h000100, "sec_carry");
      run(356);
      expect_at(23596, 24'h005999, "sec_5999");
      expect_at(23600, 24'h010000, "min_carry");
      run(23600);

      // Pause mid-hundredth, then resume.
      run(2);
      toggle = 1'b0;
      expect_at(1,  24'h010000, "pause_start");
      expect_at(20, 24'h010000, "pause_end");
      run(20);
      toggle = 1'b1;
      expect_at(1, 24'h010000, "resume_partial");
      expect_at(2, 24'h010001, "resume_tick");
      run(2);

      // Reset mid-count at 00:01.23 with toggle high.
      reset = 1'b1;
      expect_at(1, 24'h000000, "reset_clear");
      run(1);
      reset = 1'b0;
      expect_at(492, 24'h000123, "reach_123");
      run(494);
      reset = 1'b1;
      expect_at(1, 24'h000000, "reset_midcount");
      run(1);
      reset = 1'b0;
      expect_at(3, 24'h000000, "post_reset_hold");
      expect_at(4, 24'h000001, "post_reset_first");
      run(4);

      // Reset held high dominates toggle.
      reset = 1'b1;
      expect_at(5,  24'h000000, "reset_held_mid");
      expect_at(10, 24'h000000, "reset_held");
      run(10);

      // Minute tens carry from a preloaded 09:59.99.
      toggle = 1'b0;
      run(1);
      reset     = 1'b0;
      preload_v = 24'h095999;
      force dut.r_time = preload_v;
      run(1);
      release dut.r_time;
      toggle = 1'b1;
      expect_at(3, 24'h095999, "preload_095999");
      expect_at(4, 24'h100000, "min_tens_carry");
      run(4);

      // Top of range: wrap (default) or saturate.
      toggle = 1'b0;
      reset  = 1'b1;
      run(1);
      reset     = 1'b0;
      preload_v = 24'h595999;
      force dut.r_time = preload_v;
      run(1);
      release dut.r_time;
      toggle = 1'b1;
      expect_at(3, 24'h595999, "preload_595999");
`ifdef STOPWATCH_SATURATE_EN
      expect_at(4,  24'h595999, "saturate");
      expect_at(12, 24'h595999, "saturate_hold");
`else
      expect_at(4,  24'h000000, "wrap");
      expect_at(12, 24'h000002, "after_wrap");
`endif
      run(12);

      for (int i = 0; i < 100 && q.size() > 0; i++) run(1);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
